// File: rtl/lenvelope.sv
// Peak envelope follower: rectifies signed samples, holds each captured peak for
// HOLD_SAMPLES enabled samples, then releases linearly by RELEASE_STEP per sample.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | envelope is zero, waiting for a nonzero sample
// HOLD    | peak captured, envelope frozen while hold_cnt counts down
// RELEASE | envelope decaying by RELEASE_STEP, tracking input from below
module lenvelope #(
   parameter int                 W_TOTAL      = 16,
   parameter int                 W_FRAC       = 15,
   parameter int                 HOLD_SAMPLES = 64,
   parameter logic [W_TOTAL-1:0] RELEASE_STEP = 16'h0010
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      i_ce,
   input  logic signed [W_TOTAL-1:0] i_data,
   input  logic signed [W_TOTAL-1:0] i_threshold,
   output logic        [W_TOTAL-1:0] o_envelope,
   output logic                      o_over,
   output logic                      o_ce
);

   localparam int W_INT = W_TOTAL - W_FRAC;
   // largest positive value in Q(W_INT).(W_FRAC): sign bit clear, all others set
   localparam logic [W_TOTAL-1:0] MAX_POS  = {1'b0, {(W_INT + W_FRAC - 1){1'b1}}};
   localparam logic [W_TOTAL-1:0] MIN_NEG  = {1'b1, {(W_TOTAL - 1){1'b0}}};
   localparam logic [15:0]        HOLD_CNT = 16'(HOLD_SAMPLES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t               state, state_nx;
   logic [W_TOTAL-1:0]   env, env_nx;
   logic [15:0]          hold_cnt, hold_cnt_nx;
   logic [W_TOTAL-1:0]   mag;
   logic [W_TOTAL-1:0]   rel_sub;
   logic [W_TOTAL-1:0]   rel_env;
   logic                 attack;

   always_comb begin
      mag = i_data;
      if (i_data[W_TOTAL-1]) begin
         if (i_data == MIN_NEG) mag = MAX_POS;
         else                   mag = ~i_data + 1'b1;
      end
   end

   always_comb begin
      rel_sub = (env > RELEASE_STEP) ? env - RELEASE_STEP : '0;
      rel_env = (rel_sub > mag) ? rel_sub : mag;
   end

   // a zero sample never counts as a capture, so IDLE stays put on silence
   assign attack = (mag >= env) && (mag != '0);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state    <= IDLE;
         env      <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nx;
         env      <= env_nx;
         hold_cnt <= hold_cnt_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      env_nx      = env;
      hold_cnt_nx = hold_cnt;
      if (i_ce) begin
         if (attack) begin
            env_nx      = mag;
            hold_cnt_nx = HOLD_CNT;
            state_nx    = (HOLD_SAMPLES == 0) ? RELEASE : HOLD;
         end else begin
            case (state)
               IDLE: begin
                  state_nx = IDLE;
               end
               HOLD: begin
                  if (hold_cnt <= 16'd1) begin
                     hold_cnt_nx = '0;
                     state_nx    = RELEASE;
                  end else begin
                     hold_cnt_nx = hold_cnt - 16'd1;
                  end
               end
               RELEASE: begin
                  env_nx = rel_env;
                  if (rel_env == '0) state_nx = IDLE;
               end
               default: begin
                  state_nx    = IDLE;
                  env_nx      = '0;
                  hold_cnt_nx = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_over <= 1'b0;
         o_ce   <= 1'b0;
      end else begin
         o_ce <= i_ce;
         if (i_ce) o_over <= $signed(env_nx) > i_threshold;
      end
   end

   // env only moves on enabled edges, so it is already the registered envelope
   assign o_envelope = env;

endmodule

// File: tb/tb_lenvelope.sv
// Self-checking bench for lenvelope: directed scenarios plus randomized samples,
// all compared against a peak/hold/decay reference model written in plain integers.
module tb_lenvelope;

   localparam int HOLD = 4;
   localparam int STEP = 16;

   logic               clk;
   logic               rst_n;
   logic               ce_r;
   logic signed [15:0] data_r;
   logic signed [15:0] thr_r;
   logic        [15:0] env_o;
   logic               over_o;
   logic               ce_o;

   int n_checks;
   int n_errors;

   int m_env;
   int m_hold;
   bit m_over;

   lenvelope #(
      .W_TOTAL      (16),
      .W_FRAC       (15),
      .HOLD_SAMPLES (HOLD),
      .RELEASE_STEP (16'h0010)
   ) u_dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_ce        (ce_r),
      .i_data      (data_r),
      .i_threshold (thr_r),
      .o_envelope  (env_o),
      .o_over      (over_o),
      .o_ce        (ce_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int mag_of(input logic signed [15:0] d);
      int v;
      v = d;
      if (v < 0) v = -v;
      if (v > 32767) v = 32767;
      return v;
   endfunction

   // Envelope is the running peak: a new peak restarts the hold window, an
   // expired hold lets it fall by STEP per sample but never below the input.
   task automatic model_sample(input logic signed [15:0] d, input logic signed [15:0] thr);
      int mg;
      int dec;
      int thr_i;
      mg = mag_of(d);
      if (mg > 0 && mg >= m_env) begin
         m_env  = mg;
         m_hold = HOLD;
      end else if (m_hold > 0) begin
         m_hold = m_hold - 1;
      end else if (m_env > 0) begin
         dec = m_env - STEP;
         if (dec < 0) dec = 0;
         m_env = (dec > mg) ? dec : mg;
      end
      thr_i  = thr;
      m_over = (m_env > thr_i);
   endtask

   task automatic model_reset();
      m_env  = 0;
      m_hold = 0;
      m_over = 1'b0;
   endtask

   task automatic step(input logic ce, input logic signed [15:0] d, input logic signed [15:0] thr,
                       input string tag);
      @(negedge clk);
      ce_r   = ce;
      data_r = d;
      thr_r  = thr;
      @(posedge clk);
      #1;
      if (ce) model_sample(d, thr);
      chk({tag, ".ce"},   32'(ce_o),   32'(ce));
      chk({tag, ".env"},  32'(env_o),  32'(m_env));
      chk({tag, ".over"}, 32'(over_o), 32'(m_over));
   endtask

   task automatic pulse_reset(input string tag);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk({tag, ".rst_env"},  32'(env_o),  32'h0);
      chk({tag, ".rst_over"}, 32'(over_o), 32'h0);
      chk({tag, ".rst_ce"},   32'(ce_o),   32'h0);
      ce_r = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic signed [15:0] d;
      logic signed [15:0] thr;
      n_checks = 0;
      n_errors = 0;
      model_reset();

      // reset held with live-looking inputs
      rst_n  = 1'b0;
      ce_r   = 1'b1;
      data_r = 16'shFFFF;
      thr_r  = 16'sh4000;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.env",  32'(env_o),  32'h0);
      chk("reset.over", 32'(over_o), 32'h0);
      chk("reset.ce",   32'(ce_o),   32'h0);
      @(negedge clk);
      ce_r  = 1'b0;
      rst_n = 1'b1;

      // attack, negative re-capture, most-negative saturation
      step(1'b1, 16'sh5000, 16'sh4000, "atk0");
      chk("atk0.const", 32'(env_o), 32'h5000);
      chk("atk0.over1", 32'(over_o), 32'h1);
      step(1'b1, 16'shB000, 16'sh4000, "atk1");
      chk("atk1.const", 32'(env_o), 32'h5000);
      step(1'b1, 16'sh8000, 16'sh4000, "atk2");
      chk("atk2.sat", 32'(env_o), 32'h7FFF);

      // hold for exactly HOLD samples, then linear release across the threshold
      pulse_reset("r1");
      step(1'b1, 16'sh5000, 16'sh4000, "hr.cap");
      for (int i = 0; i < HOLD; i++) begin
         step(1'b1, 16'sh0000, 16'sh4000, "hr.hold");
         chk("hr.hold_const", 32'(env_o), 32'h5000);
      end
      step(1'b1, 16'sh0000, 16'sh4000, "hr.rel1");
      chk("hr.rel1_const", 32'(env_o), 32'h4FF0);
      step(1'b1, 16'sh0000, 16'sh4000, "hr.rel2");
      chk("hr.rel2_const", 32'(env_o), 32'h4FE0);
      for (int i = 0; i < 260; i++) begin
         step(1'b1, 16'sh0000, 16'sh4000, "hr.decay");
         if (env_o == 16'h4010) chk("hr.over_above", 32'(over_o), 32'h1);
         if (env_o == 16'h4000) chk("hr.over_at_thr", 32'(over_o), 32'h0);
      end

      // release floor clamps at zero
      pulse_reset("r2");
      step(1'b1, 16'sh0018, 16'sh4000, "fl.cap");
      for (int i = 0; i < HOLD; i++) step(1'b1, 16'sh0000, 16'sh4000, "fl.hold");
      step(1'b1, 16'sh0000, 16'sh4000, "fl.r1");
      chk("fl.r1_const", 32'(env_o), 32'h0008);
      step(1'b1, 16'sh0000, 16'sh4000, "fl.r2");
      chk("fl.r2_const", 32'(env_o), 32'h0000);
      chk("fl.r2_over", 32'(over_o), 32'h0);
      step(1'b1, 16'sh0000, 16'sh4000, "fl.idle");
      chk("fl.idle_const", 32'(env_o), 32'h0000);

      // release tracks an input just below the envelope
      pulse_reset("r3");
      step(1'b1, 16'sh1010, 16'sh4000, "tr.cap");
      for (int i = 0; i < HOLD; i++) step(1'b1, 16'sh0000, 16'sh4000, "tr.hold");
      step(1'b1, 16'sh0000, 16'sh4000, "tr.r1");
      chk("tr.r1_const", 32'(env_o), 32'h1000);
      step(1'b1, 16'sh0FF8, 16'sh4000, "tr.track");
      chk("tr.track_const", 32'(env_o), 32'h0FF8);
      step(1'b1, 16'sh0000, 16'sh4000, "tr.still_rel");
      chk("tr.still_rel_const", 32'(env_o), 32'h0FE8);

      // gating during hold freezes everything including the hold count
      pulse_reset("r4");
      step(1'b1, 16'sh5000, 16'sh4000, "gt.cap");
      step(1'b1, 16'sh0000, 16'sh4000, "gt.h1");
      step(1'b1, 16'sh0000, 16'sh4000, "gt.h2");
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 16'sh7000, 16'sh0000, "gt.off");
         chk("gt.off_ce", 32'(ce_o), 32'h0);
         chk("gt.off_env", 32'(env_o), 32'h5000);
      end
      step(1'b1, 16'sh0000, 16'sh4000, "gt.h3");
      step(1'b1, 16'sh0000, 16'sh4000, "gt.h4");
      chk("gt.h4_const", 32'(env_o), 32'h5000);
      step(1'b1, 16'sh0000, 16'sh4000, "gt.rel");
      chk("gt.rel_const", 32'(env_o), 32'h4FF0);
      step(1'b1, 16'sh6000, 16'sh4000, "gt.recap");
      step(1'b1, 16'sh0000, 16'sh4000, "gt.recap_h");
      pulse_reset("gt.midhold");
      step(1'b1, 16'sh0000, 16'sh4000, "gt.after_rst");

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 7))
            0, 1, 2: d = 16'sh0000;
            3:       d = 16'sh8000;
            4:       d = 16'($urandom_range(0, 64)) * (($urandom_range(0, 1) == 1) ? -16'sd1 : 16'sd1);
            5:       d = 16'($urandom);
            6:       d = 16'(m_env - $urandom_range(0, 40));
            default: d = 16'($urandom_range(0, 16'h0400));
         endcase
         case ($urandom_range(0, 3))
            0:       thr = 16'(m_env);
            1:       thr = 16'((m_env > 0) ? m_env - 1 : 0);
            default: thr = 16'($urandom_range(0, 16'h7FFF));
         endcase
         step(($urandom_range(0, 9) < 7), d, thr, "rnd");
         if ($urandom_range(0, 499) == 0) pulse_reset("rnd.rst");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
